// File: rtl/wifi_pkg.sv
// Shared 802.11a transmit-chain constants: RATE codes, bits per subcarrier, subcarrier count.
package wifi_pkg;

    localparam int unsigned NSD     = 48;
    localparam int unsigned QAM_OW  = 4;
    localparam int unsigned NBPSC_W = 3;

    typedef logic [NBPSC_W-1:0] nbpsc_t;

    localparam nbpsc_t NBPSC_BPSK  = 3'd1;
    localparam nbpsc_t NBPSC_QPSK  = 3'd2;
    localparam nbpsc_t NBPSC_16QAM = 3'd4;
    localparam nbpsc_t NBPSC_64QAM = 3'd6;

    localparam logic [3:0] RATE_6  = 4'b1101;
    localparam logic [3:0] RATE_9  = 4'b1111;
    localparam logic [3:0] RATE_12 = 4'b0101;
    localparam logic [3:0] RATE_18 = 4'b0111;
    localparam logic [3:0] RATE_24 = 4'b1001;
    localparam logic [3:0] RATE_36 = 4'b1011;
    localparam logic [3:0] RATE_48 = 4'b0001;
    localparam logic [3:0] RATE_54 = 4'b0011;

    // Coded bits per subcarrier for a RATE field; unknown codes fall back to BPSK.
    function automatic nbpsc_t rate_to_nbpsc(input logic [3:0] rate);
        case (rate)
            RATE_6,  RATE_9:  return NBPSC_BPSK;
            RATE_12, RATE_18: return NBPSC_QPSK;
            RATE_24, RATE_36: return NBPSC_16QAM;
            RATE_48, RATE_54: return NBPSC_64QAM;
            default:          return NBPSC_BPSK;
        endcase
    endfunction

endpackage

// File: rtl/qam_mapper_if.sv
// Bit stream in, complex subcarrier points out, between interleaver and IFFT stages.
interface qam_mapper_if #(
    parameter int unsigned OW = 4
);
    logic                 Start;
    logic [3:0]           Rate;
    logic                 x;
    logic                 x_valid;
    logic signed [OW-1:0] I;
    logic signed [OW-1:0] Q;
    logic                 Valid;
    logic [5:0]           Subc;
    logic                 Last;

    modport master (
        output Start, Rate, x, x_valid,
        input  I, Q, Valid, Subc, Last
    );

    modport slave (
        input  Start, Rate, x, x_valid,
        output I, Q, Valid, Subc, Last
    );
endinterface

// File: rtl/qam_gray_lut.sv
// Combinational Gray mapping of one bit group (bits[0] = b0) to unnormalised I/Q levels.
module qam_gray_lut #(
    parameter int unsigned OW = 4
) (
    input  wifi_pkg::nbpsc_t     nbpsc,
    input  logic [5:0]           bits,
    output logic signed [OW-1:0] i_c,
    output logic signed [OW-1:0] q_c
);
    import wifi_pkg::*;

    // Single bit: 0 -> -1, 1 -> +1.
    function automatic logic signed [OW-1:0] gray1(input logic b);
        return b ? OW'(1) : OW'(-1);
    endfunction

    // Two-bit Gray axis for 16-QAM.
    function automatic logic signed [OW-1:0] gray2(input logic [1:0] b);
        case (b)
            2'b00:   return OW'(-3);
            2'b01:   return OW'(-1);
            2'b11:   return OW'(1);
            default: return OW'(3);
        endcase
    endfunction

    // Three-bit Gray axis for 64-QAM.
    function automatic logic signed [OW-1:0] gray3(input logic [2:0] b);
        case (b)
            3'b000:  return OW'(-7);
            3'b001:  return OW'(-5);
            3'b011:  return OW'(-3);
            3'b010:  return OW'(-1);
            3'b110:  return OW'(1);
            3'b111:  return OW'(3);
            3'b101:  return OW'(5);
            default: return OW'(7);
        endcase
    endfunction

    // Select the axis mapping by modulation order.
    always_comb begin
        i_c = '0;
        q_c = '0;
        case (nbpsc)
            NBPSC_QPSK: begin
                i_c = gray1(bits[0]);
                q_c = gray1(bits[1]);
            end
            NBPSC_16QAM: begin
                i_c = gray2({bits[0], bits[1]});
                q_c = gray2({bits[2], bits[3]});
            end
            NBPSC_64QAM: begin
                i_c = gray3({bits[0], bits[1], bits[2]});
                q_c = gray3({bits[3], bits[4], bits[5]});
            end
            default: begin
                i_c = gray1(bits[0]);
                q_c = '0;
            end
        endcase
    end

endmodule

// File: rtl/qam_mapper.sv
// 802.11a subcarrier mapper: groups serial coded bits and emits one Gray-mapped point per subcarrier.
module qam_mapper #(
    parameter int unsigned NSD = wifi_pkg::NSD,
    parameter int unsigned OW  = wifi_pkg::QAM_OW
) (
    input  logic         Clk,
    input  logic         Reset,
    qam_mapper_if.slave  bus
);
    import wifi_pkg::*;

    localparam logic [0:0]  IDLE   = 1'b0;
    localparam logic [0:0]  ACTIVE = 1'b1;
    localparam int unsigned SUBC_W = 6;

    logic [0:0]           state_q, state_d;
    nbpsc_t               nbpsc_q, nbpsc_d, nbpsc_cur;
    nbpsc_t               bit_cnt_q, bit_cnt_d;
    logic [5:0]           sr_q, sr_d, group_c;
    logic [SUBC_W-1:0]    subc_cnt_q, subc_cnt_d;
    logic [SUBC_W-1:0]    subc_q, subc_d;
    logic signed [OW-1:0] i_q, i_d, q_q, q_d, lut_i, lut_q;
    logic                 valid_q, valid_d, last_q, last_d;
    logic                 accept, emit;

    // Rate is taken live while idle and frozen once a frame is running.
    always_comb begin
        nbpsc_cur = (state_q == IDLE) ? rate_to_nbpsc(bus.Rate) : nbpsc_q;
        accept    = bus.Start && bus.x_valid;
        group_c   = sr_q;
        group_c[bit_cnt_q] = bus.x;
        emit      = accept && (bit_cnt_q == nbpsc_cur - 3'd1);
    end

    qam_gray_lut #(.OW(OW)) u_lut (
        .nbpsc (nbpsc_cur),
        .bits  (group_c),
        .i_c   (lut_i),
        .q_c   (lut_q)
    );

    // Next-state: frame start/abort, bit collection and point emission.
    always_comb begin
        state_d    = state_q;
        nbpsc_d    = nbpsc_q;
        bit_cnt_d  = bit_cnt_q;
        sr_d       = sr_q;
        subc_cnt_d = subc_cnt_q;
        valid_d    = 1'b0;
        i_d        = i_q;
        q_d        = q_q;
        subc_d     = subc_q;
        last_d     = last_q;

        if (state_q == IDLE) begin
            if (accept) begin
                state_d = ACTIVE;
                nbpsc_d = nbpsc_cur;
            end
        end else if (!bus.Start) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            sr_d       = '0;
            subc_cnt_d = '0;
        end

        if (accept) begin
            if (emit) begin
                valid_d    = 1'b1;
                i_d        = lut_i;
                q_d        = lut_q;
                subc_d     = subc_cnt_q;
                last_d     = (subc_cnt_q == SUBC_W'(NSD - 1));
                subc_cnt_d = (subc_cnt_q == SUBC_W'(NSD - 1)) ? '0 : subc_cnt_q + 6'd1;
                bit_cnt_d  = '0;
                sr_d       = '0;
            end else begin
                bit_cnt_d  = bit_cnt_q + 3'd1;
                sr_d       = group_c;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            nbpsc_q    <= NBPSC_BPSK;
            bit_cnt_q  <= '0;
            sr_q       <= '0;
            subc_cnt_q <= '0;
            valid_q    <= 1'b0;
            i_q        <= '0;
            q_q        <= '0;
            subc_q     <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            nbpsc_q    <= nbpsc_d;
            bit_cnt_q  <= bit_cnt_d;
            sr_q       <= sr_d;
            subc_cnt_q <= subc_cnt_d;
            valid_q    <= valid_d;
            i_q        <= i_d;
            q_q        <= q_d;
            subc_q     <= subc_d;
            last_q     <= last_d;
        end
    end

    assign bus.I     = i_q;
    assign bus.Q     = q_q;
    assign bus.Valid = valid_q;
    assign bus.Subc  = subc_q;
    assign bus.Last  = last_q;

endmodule

// File: tb/tb_qam_mapper.sv
// Directed-vector bench for qam_mapper.
module tb_qam_mapper;

    logic Clk;
    logic Reset;
    int   checks;
    int   failures;
    int   vcnt;

    qam_mapper_if #(.OW(4)) bus ();

    qam_mapper #(.NSD(48), .OW(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Present one cycle of input, then land on the next falling edge with outputs settled.
    task automatic tick(input logic s, input logic v, input logic b);
        bus.Start   = s;
        bus.x_valid = v;
        bus.x       = b;
        @(negedge Clk);
        if (bus.Valid) vcnt++;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        vcnt        = 0;
        Reset       = 1'b1;
        bus.Start   = 1'b0;
        bus.x_valid = 1'b0;
        bus.x       = 1'b0;
        bus.Rate    = 4'b1101;
        @(negedge Clk);
        @(negedge Clk);
        chk("rst_i",     int'(bus.I), 0);
        chk("rst_q",     int'(bus.Q), 0);
        chk("rst_valid", int'(bus.Valid), 0);
        chk("rst_subc",  int'(bus.Subc), 0);
        chk("rst_last",  int'(bus.Last), 0);
        Reset = 1'b0;
        tick(0, 0, 0);

        // BPSK back-to-back points
        bus.Rate = 4'b1101;
        tick(1, 1, 1);
        chk("bpsk0_valid", int'(bus.Valid), 1);
        chk("bpsk0_i",     int'(bus.I), 1);
        chk("bpsk0_q",     int'(bus.Q), 0);
        chk("bpsk0_subc",  int'(bus.Subc), 0);
        tick(1, 1, 0);
        chk("bpsk1_valid", int'(bus.Valid), 1);
        chk("bpsk1_i",     int'(bus.I), -1);
        chk("bpsk1_subc",  int'(bus.Subc), 1);
        tick(0, 0, 0);
        chk("bpsk_end_valid", int'(bus.Valid), 0);

        // 16-QAM with an x_valid gap
        bus.Rate = 4'b1001;
        vcnt = 0;
        tick(1, 1, 1);
        tick(1, 1, 0);
        tick(1, 0, 0);
        tick(1, 0, 1);
        tick(1, 0, 0);
        chk("qam16_gap_novalid", vcnt, 0);
        tick(1, 1, 0);
        chk("qam16_early_valid", int'(bus.Valid), 0);
        tick(1, 1, 1);
        chk("qam16_valid", int'(bus.Valid), 1);
        chk("qam16_i",     int'(bus.I), 3);
        chk("qam16_q",     int'(bus.Q), -1);
        chk("qam16_subc",  int'(bus.Subc), 0);
        tick(1, 0, 0);
        chk("qam16_count", vcnt, 1);
        tick(0, 0, 0);

        // 64-QAM with a Rate change mid-group
        bus.Rate = 4'b0011;
        vcnt = 0;
        tick(1, 1, 0);
        bus.Rate = 4'b1101;
        tick(1, 1, 1);
        tick(1, 1, 1);
        tick(1, 1, 1);
        tick(1, 1, 0);
        chk("qam64_early", vcnt, 0);
        tick(1, 1, 0);
        chk("qam64_valid", int'(bus.Valid), 1);
        chk("qam64_i",     int'(bus.I), -3);
        chk("qam64_q",     int'(bus.Q), 7);
        chk("qam64_count", vcnt, 1);
        tick(0, 0, 0);

        // QPSK across an OFDM-symbol boundary
        bus.Rate = 4'b0101;
        vcnt = 0;
        for (int n = 0; n < 98; n++) begin
            tick(1, 1, 1);
            chk("qpsk_valid", int'(bus.Valid), n % 2);
            if (bus.Valid) begin
                chk("qpsk_i",    int'(bus.I), 1);
                chk("qpsk_q",    int'(bus.Q), 1);
                chk("qpsk_subc", int'(bus.Subc), ((n - 1) / 2) % 48);
                chk("qpsk_last", int'(bus.Last), (((n - 1) / 2) % 48 == 47) ? 1 : 0);
            end
        end
        chk("qpsk_count", vcnt, 49);
        chk("qpsk_wrap_subc", int'(bus.Subc), 0);

        // Abort mid-group (x_valid high with Start low is not a bit), then restart
        tick(0, 0, 0);
        bus.Rate = 4'b0001;
        vcnt = 0;
        tick(1, 1, 1);
        tick(1, 1, 1);
        tick(1, 1, 1);
        tick(0, 1, 1);
        chk("abort_valid", int'(bus.Valid), 0);
        tick(1, 1, 1);
        tick(1, 1, 0);
        tick(1, 1, 0);
        chk("abort_discard", vcnt, 0);
        tick(1, 1, 1);
        tick(1, 1, 0);
        tick(1, 1, 0);
        chk("restart_valid", int'(bus.Valid), 1);
        chk("restart_i",     int'(bus.I), 7);
        chk("restart_q",     int'(bus.Q), 7);
        chk("restart_subc",  int'(bus.Subc), 0);
        chk("restart_count", vcnt, 1);
        tick(0, 0, 0);

        // Asynchronous reset while mid-group
        bus.Rate = 4'b0101;
        tick(1, 1, 1);
        tick(1, 1, 1);
        tick(1, 1, 0);
        tick(1, 1, 0);
        chk("pre_rst_i",    int'(bus.I), -1);
        chk("pre_rst_subc", int'(bus.Subc), 1);
        tick(1, 1, 1);
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_i",     int'(bus.I), 0);
        chk("arst_q",     int'(bus.Q), 0);
        chk("arst_valid", int'(bus.Valid), 0);
        chk("arst_subc",  int'(bus.Subc), 0);
        bus.Start   = 1'b0;
        bus.x_valid = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        vcnt = 0;
        tick(0, 0, 0);
        tick(1, 1, 0);
        chk("post_rst_early", int'(bus.Valid), 0);
        tick(1, 1, 1);
        chk("post_rst_valid", int'(bus.Valid), 1);
        chk("post_rst_i",     int'(bus.I), -1);
        chk("post_rst_q",     int'(bus.Q), 1);
        chk("post_rst_subc",  int'(bus.Subc), 0);
        tick(0, 0, 0);
        chk("post_rst_count", vcnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
